layer_scheduler: RTL and testbench
==================================

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 3, giving the number of chained layers (conv, conv1, dense).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum WAIT cycles per layer before an error.
REQ-003 The block SHALL have port clock  input  1  the single clock; all logic on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port frame_valid  input  1  a new image is present on the image bus.
REQ-006 The block SHALL have port frame_ready  output  1  the scheduler accepts a frame this cycle.
REQ-007 The block SHALL have port layer_start  output  NUM_LAYERS  one-hot, single-cycle start pulse per layer.
REQ-008 The block SHALL have port layer_done  input  NUM_LAYERS  per-layer done pulse or level.
REQ-009 The block SHALL have port result_valid  output  1  the final layer output is valid.
REQ-010 The block SHALL have port result_ready  input  1  the consumer takes the result.
REQ-011 The block SHALL have port clear  input  1  leaves ERROR.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port active_layer  output  2  index of the layer being started or awaited; 0 in IDLE.
REQ-014 The block SHALL have port error  output  1  a timeout is latched.
REQ-015 The block SHALL have port err_layer  output  2  index of the layer that timed out.
REQ-016 The block SHALL have port frame_cycles  output  32  clock count from the first layer_start to the last layer_done of the most recent frame.

Function
REQ-017 The FSM SHALL have the states IDLE, START, WAIT, RESULT and ERROR, plus a layer index k.
REQ-018 frame_ready SHALL equal (state==IDLE); a frame is accepted when frame_valid && frame_ready.
REQ-019 On acceptance in cycle T, the FSM SHALL set k=0 and enter START, so that layer_start[0]=1 in cycle T+1.
REQ-020 START SHALL last exactly one cycle, asserting layer_start[k] only, then go to WAIT.
REQ-021 In WAIT, layer_done[k]=1 SHALL end the wait. If k<NUM_LAYERS-1, k increments and the FSM enters START, so the next start pulse comes 1 cycle after done. Otherwise the FSM enters RESULT.
REQ-022 layer_done bits other than bit k, and any layer_done seen during START, SHALL be ignored.
REQ-023 The WAIT counter SHALL clear on entry to WAIT. If it reaches TIMEOUT_CYCLES without done, the FSM SHALL enter ERROR with error=1 and err_layer=k.
REQ-024 In RESULT, result_valid SHALL be 1. It SHALL stay 1 until result_ready=1, after which the FSM enters IDLE the next cycle. A result_ready asserted early SHALL have no effect.
REQ-025 frame_valid SHALL be ignored outside IDLE, and no frame SHALL be queued.
REQ-026 In ERROR, layer_start and result_valid SHALL be 0. clear=1 SHALL go to IDLE, clear error, and keep err_layer.
REQ-027 If clear=1 outside ERROR, it SHALL have no effect.
REQ-028 The frame counter SHALL start at 0 in the START cycle of layer 0 and increment every cycle through the final done cycle, saturating at 0xFFFFFFFF.
REQ-029 frame_cycles SHALL update in the cycle RESULT is entered and SHALL hold otherwise.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL enter IDLE, overriding any other event, including reset in mid-WAIT or in RESULT.
REQ-032 Reset SHALL set k=0, layer_start=0, result_valid=0, busy=0, active_layer=0, error=0, err_layer=0 and frame_cycles=0; frame_ready=1 in the first cycle after reset.

Structure
REQ-033 Shared package cnn_ctrl_pkg SHALL hold the state enum, the layer index constants (L_CONV0=0, L_CONV1=1, L_DENSE=2) and the default TIMEOUT_CYCLES.
REQ-034 One sub-module, layer_watchdog, SHALL provide the clearable timeout counter (clear, enable, expired).

Verification
REQ-035 Nominal: frame_valid in cycle 0, dones 10, 20 and 5 cycles after each start -> start pulses at cycles 1, 12 and 33; result_valid at 39; frame_cycles=38.
REQ-036 Backpressure: hold result_ready=0 for 7 cycles -> result_valid stays 1, frame_ready=0, and a second frame_valid is not accepted; on result_ready=1, IDLE follows the next cycle.
REQ-037 Timeout (TIMEOUT_CYCLES=16): no done for layer 1 -> error=1 and err_layer=1 after 16 WAIT cycles; clear -> IDLE with error=0.
REQ-038 Stray/early done: layer_done[2] during the layer-0 WAIT, and layer_done[0] during the START of layer 0 -> both ignored, and the sequence completes normally.
REQ-039 Reset mid-WAIT of layer 1 -> all outputs at reset values next cycle; a new frame then runs from layer 0.
REQ-040 Back-to-back: result_ready tied high and frame_valid tied high -> frames are accepted one cycle after each RESULT, with no lost start pulses.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// rtl/cnn_ctrl_pkg.sv - shared types and constants for the CNN layer scheduler
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESULT,
    S_ERROR
  } state_t;

  localparam int L_CONV0 = 0;
  localparam int L_CONV1 = 1;
  localparam int L_DENSE = 2;

  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/layer_watchdog.sv
// rtl/layer_watchdog.sv - clearable per-layer wait timeout counter
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the count (held while the scheduler is not waiting)
//   enable       : count one cycle of waiting
//   expired      : this is the last permitted wait cycle without a done
module layer_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // count holds the number of wait cycles already completed, so the
  // TIMEOUT_CYCLES-th wait cycle is the one where count == TIMEOUT_CYCLES-1.
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - sequences one frame through the chained CNN layers
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   frame_valid/ready    : frame handshake, ready only in IDLE
//   layer_start          : one-hot single-cycle start pulse per layer
//   layer_done           : per-layer done, only bit k is looked at in WAIT
//   result_valid/ready   : final result handshake
//   clear                : leaves ERROR
//   busy, active_layer   : status
//   error, err_layer     : latched timeout and the layer that timed out
//   frame_cycles         : first start to last done cycle count of last frame
module layer_scheduler
  import cnn_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  result_valid,
  input  logic                  result_ready,
  input  logic                  clear,
  output logic                  busy,
  output logic [1:0]            active_layer,
  output logic                  error,
  output logic [1:0]            err_layer,
  output logic [31:0]           frame_cycles
);

  localparam logic [NUM_LAYERS-1:0] ONE   = NUM_LAYERS'(1);
  localparam logic [1:0]            FIRST = 2'(L_CONV0);
  localparam logic [1:0]            LAST  = 2'(NUM_LAYERS - 1);

  state_t      state;
  logic [1:0]  k;
  logic [31:0] cnt;
  logic        expired;

  layer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != S_WAIT),
    .enable (state == S_WAIT),
    .expired(expired)
  );

  // Outputs are assigned together with the transition that produces them,
  // so every output reflects the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      k            <= FIRST;
      cnt          <= '0;
      frame_ready  <= 1'b1;
      layer_start  <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      active_layer <= '0;
      error        <= 1'b0;
      err_layer    <= '0;
      frame_cycles <= '0;
    end else begin
      layer_start <= '0;
      case (state)
        S_IDLE: begin
          if (frame_valid) begin
            state        <= S_START;
            k            <= FIRST;
            cnt          <= '0;
            layer_start  <= ONE << FIRST;
            frame_ready  <= 1'b0;
            busy         <= 1'b1;
            active_layer <= FIRST;
          end
        end
        S_START: begin
          state <= S_WAIT;
          cnt   <= sat_inc(cnt);
        end
        S_WAIT: begin
          if (layer_done[k]) begin
            // The done cycle itself is part of the frame time.
            cnt <= sat_inc(cnt);
            if (k == LAST) begin
              state        <= S_RESULT;
              result_valid <= 1'b1;
              frame_cycles <= sat_inc(cnt);
            end else begin
              state        <= S_START;
              k            <= k + 2'd1;
              layer_start  <= ONE << (k + 2'd1);
              active_layer <= k + 2'd1;
            end
          end else if (expired) begin
            state     <= S_ERROR;
            error     <= 1'b1;
            err_layer <= k;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_RESULT: begin
          if (result_ready) begin
            state        <= S_IDLE;
            k            <= FIRST;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            frame_ready  <= 1'b1;
            active_layer <= '0;
          end
        end
        S_ERROR: begin
          // err_layer is kept for post-mortem after clear.
          if (clear) begin
            state        <= S_IDLE;
            k            <= FIRST;
            error        <= 1'b0;
            busy         <= 1'b0;
            frame_ready  <= 1'b1;
            active_layer <= '0;
          end
        end
        default: begin
          state        <= S_IDLE;
          k            <= FIRST;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          frame_ready  <= 1'b1;
          active_layer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - self-checking bench for layer_scheduler
module tb_layer_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [2:0]  layer_done = '0;
  logic        result_ready = 1'b0;
  logic        clear = 1'b0;

  logic        frame_ready, result_valid, busy, error;
  logic [2:0]  layer_start;
  logic [1:0]  active_layer, err_layer;
  logic [31:0] frame_cycles;

  logic        to_frame_ready, to_result_valid, to_busy, to_error;
  logic [2:0]  to_layer_start;
  logic [1:0]  to_active_layer, to_err_layer;
  logic [31:0] to_frame_cycles;

  int checks = 0;
  int errors = 0;
  int last_fc = 0;

  always #5 clock = ~clock;

  layer_scheduler dut (
    .clock(clock), .reset(reset), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .layer_start(layer_start), .layer_done(layer_done), .result_valid(result_valid),
    .result_ready(result_ready), .clear(clear), .busy(busy), .active_layer(active_layer),
    .error(error), .err_layer(err_layer), .frame_cycles(frame_cycles)
  );

  layer_scheduler #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(16)) dut_to (
    .clock(clock), .reset(reset), .frame_valid(frame_valid), .frame_ready(to_frame_ready),
    .layer_start(to_layer_start), .layer_done(layer_done), .result_valid(to_result_valid),
    .result_ready(result_ready), .clear(clear), .busy(to_busy), .active_layer(to_active_layer),
    .error(to_error), .err_layer(to_err_layer), .frame_cycles(to_frame_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"},  32'(layer_start), 0);
    check({tag, "_rvalid"}, 32'(result_valid), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_active"}, 32'(active_layer), 0);
    check({tag, "_error"},  32'(error), 0);
    check({tag, "_errl"},   32'(err_layer), 0);
    check({tag, "_fc"},     frame_cycles, 0);
    check({tag, "_fready"}, 32'(frame_ready), 1);
  endtask

  // One frame from IDLE. Reference timeline: start0 one cycle after the
  // frame is offered, each done d cycles after its start, next start one
  // cycle after a done, result one cycle after the last done, held rd extra
  // cycles of backpressure. Returns observed start cycles.
  task automatic run_frame(input int d0, input int d1, input int d2, input int rd,
                           input bit stray, output int obs_s[3], output int obs_r);
    int s[3], e[3], d[3], r, fc;
    logic [2:0] exp_ls, dn;
    d = '{d0, d1, d2};
    s[0] = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) s[i] = e[i-1] + 1;
      e[i] = s[i] + d[i];
    end
    r  = e[2] + 1;
    fc = e[2] - s[0] + 1;
    obs_s = '{-1, -1, -1};
    obs_r = -1;
    check("idle_fready", 32'(frame_ready), 1);
    frame_valid = 1'b1;
    for (int c = 1; c <= r + rd + 1; c++) begin
      step();
      exp_ls = '0;
      for (int i = 0; i < 3; i++) begin
        if (c == s[i]) exp_ls[i] = 1'b1;
        if (layer_start[i] && obs_s[i] < 0) obs_s[i] = c;
      end
      if (result_valid && obs_r < 0) obs_r = c;
      check("layer_start", 32'(layer_start), 32'(exp_ls));
      if (c <= r + rd) begin
        check("busy", 32'(busy), 1);
        check("fready_busy", 32'(frame_ready), 0);
        check("result_valid", 32'(result_valid), 32'(c >= r));
        if (c < r) begin
          for (int i = 0; i < 3; i++)
            if (c >= s[i] && c <= e[i]) check("active_layer", 32'(active_layer), 32'(i));
          check("fc_hold", frame_cycles, 32'(last_fc));
        end else begin
          check("frame_cycles", frame_cycles, 32'(fc));
        end
      end else begin
        check("idle_after_result_fready", 32'(frame_ready), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_rvalid", 32'(result_valid), 0);
        check("idle_active", 32'(active_layer), 0);
        check("fc_final", frame_cycles, 32'(fc));
      end
      // drive inputs for cycle c
      dn = '0;
      for (int i = 0; i < 3; i++) if (c == e[i]) dn[i] = 1'b1;
      if (stray && c == s[0]) dn[0] = 1'b1;
      if (stray && c > s[0] && c < e[0]) dn[2] = 1'b1;
      layer_done   = dn;
      frame_valid  = (c >= r) && (c < r + rd);
      result_ready = (c >= r + rd && c <= r + rd) || (stray && c < r && c[0]);
    end
    frame_valid  = 1'b0;
    layer_done   = '0;
    result_ready = 1'b0;
    last_fc = fc;
  endtask

  initial begin
    int os[3], orr;
    int nres, starts, last_r, done_at, cur;
    bit stray;

    // reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_values("reset");

    // nominal: dones 10, 20, 5 after each start
    run_frame(10, 20, 5, 0, 1'b0, os, orr);
    check("nom_start0", 32'(os[0]), 1);
    check("nom_start1", 32'(os[1]), 12);
    check("nom_start2", 32'(os[2]), 33);
    check("nom_result", 32'(orr), 39);
    check("nom_fc", frame_cycles, 38);

    // backpressure: 7 cycles without result_ready, frame_valid poked meanwhile
    run_frame(3, 4, 2, 7, 1'b0, os, orr);

    // stray/early done and early result_ready
    run_frame(6, 3, 4, 1, 1'b1, os, orr);

    // randomized frames
    for (int n = 0; n < 8; n++) begin
      int a, b, cc;
      a = $urandom_range(1, 25);
      b = $urandom_range(1, 25);
      cc = $urandom_range(1, 25);
      stray = (a >= 2) && ($urandom_range(0, 1) == 1);
      run_frame(a, b, cc, $urandom_range(0, 4), stray, os, orr);
    end

    // reset in mid-WAIT of layer 1
    frame_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      frame_valid = 1'b0;
      if (c == 4) check("rst_mid_start1", 32'(layer_start), 32'(3'b010));
      layer_done = (c == 3) ? 3'b001 : 3'b000;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_fc = 0;
    check_reset_values("rst_mid");
    run_frame(2, 5, 3, 0, 1'b0, os, orr);
    check("rst_new_start0", 32'(os[0]), 1);

    // back-to-back frames with result_ready and frame_valid tied high
    result_ready = 1'b1;
    frame_valid  = 1'b1;
    nres = 0; starts = 0; last_r = -10; done_at = -1; cur = 0;
    for (int c = 1; c <= 400 && nres < 3; c++) begin
      step();
      layer_done = '0;
      if (layer_start != 3'b000) begin
        starts++;
        for (int i = 0; i < 3; i++) if (layer_start[i]) cur = i;
        done_at = c + $urandom_range(1, 6);
        if (layer_start[0] && nres > 0) check("b2b_gap", 32'(c), 32'(last_r + 2));
      end
      if (result_valid) begin
        check("b2b_starts", 32'(starts), 3);
        starts = 0;
        nres++;
        last_r = c;
      end
      if (c == done_at) layer_done[cur] = 1'b1;
    end
    check("b2b_results", 32'(nres), 3);
    frame_valid  = 1'b0;
    result_ready = 1'b0;
    layer_done   = '0;

    // timeout on the TIMEOUT_CYCLES=16 instance
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("to_reset_error", 32'(to_error), 0);
    frame_valid = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      frame_valid = 1'b0;
      if (c == 1)  check("to_start0", 32'(to_layer_start), 32'(3'b001));
      if (c == 4)  check("to_start1", 32'(to_layer_start), 32'(3'b010));
      if (c == 20) check("to_not_yet", 32'(to_error), 0);
      if (c == 21) begin
        check("to_error", 32'(to_error), 1);
        check("to_err_layer", 32'(to_err_layer), 1);
        check("to_err_start", 32'(to_layer_start), 0);
        check("to_err_rvalid", 32'(to_result_valid), 0);
        check("to_err_busy", 32'(to_busy), 1);
      end
      if (c == 22) begin
        check("to_clr_error", 32'(to_error), 0);
        check("to_clr_errl", 32'(to_err_layer), 1);
        check("to_clr_fready", 32'(to_frame_ready), 1);
        check("to_clr_busy", 32'(to_busy), 0);
      end
      layer_done = (c == 3) ? 3'b001 : 3'b000;
      clear      = (c == 10) || (c == 21);
    end
    clear = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
